fsm_a_driver: RTL

Transmit-side counterpart of the A/K2/K1 sequence-detector state machine. It accepts a command over a valid/ready handshake and drives the A line through one full detector cycle: high, low, high, low, with each level held for a programmable number of clocks. It then monitors the detector's K2/K1 responses and reports a single pass/fail result. The block sits beside the detector as its stimulus source and self-checker in the control-sequence subsystem.

---
 rtl/fsm_a_driver.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fsm_a_driver.sv
// Stimulus source and self-checker for the A/K2/K1 sequence detector: drives A high/low/high/low
// with a programmable hold per level, then watches K2/K1 and reports a one-cycle pass/fail result.
module fsm_a_driver #(
  parameter int unsigned HOLD_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              A,
  input  logic              K2,
  input  logic              K1,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  localparam int unsigned TO_W = 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_P3,
    S_P4,
    S_CHECK
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;  // latched N-1, reload value for each level
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              spur_q, spur_d;
  logic              k2_q, k2_d;
  logic              k1_q, k1_d;
  logic              oerr_q, oerr_d;
  logic              a_q, a_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  // State and datapath registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      spur_q  <= 1'b0;
      k2_q    <= 1'b0;
      k1_q    <= 1'b0;
      oerr_q  <= 1'b0;
      a_q     <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      spur_q  <= spur_d;
      k2_q    <= k2_d;
      k1_q    <= k1_d;
      oerr_q  <= oerr_d;
      a_q     <= a_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state, sticky flags and result
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    spur_d  = spur_q;
    k2_d    = k2_q;
    k1_d    = k1_q;
    oerr_d  = oerr_q;
    done_d  = 1'b0;
    pass_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          hold_d  = (cmd_hold == '0) ? '0 : cmd_hold - HOLD_W'(1);
          cnt_d   = hold_d;
          to_d    = '0;
          spur_d  = 1'b0;
          k2_d    = 1'b0;
          k1_d    = 1'b0;
          oerr_d  = 1'b0;
          state_d = S_P1;
        end
      end
      S_P1, S_P2: begin
        spur_d = spur_q | K2 | K1;
      end
      S_P3: begin
        k2_d   = k2_q | K2;
        oerr_d = oerr_q | (K1 & ~k2_d);
      end
      S_P4, S_CHECK: begin
        // K2 is folded in before the ordering test, so a simultaneous K1/K2 is in order
        k2_d   = k2_q | K2;
        k1_d   = k1_q | K1;
        oerr_d = oerr_q | (K1 & ~k2_d);
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q inside {S_P1, S_P2, S_P3, S_P4}) begin
      if (cnt_q == '0) begin
        cnt_d = hold_q;
        case (state_q)
          S_P1:    state_d = S_P2;
          S_P2:    state_d = S_P3;
          S_P3:    state_d = S_P4;
          default: begin
            state_d = S_CHECK;
            to_d    = '0;
          end
        endcase
      end else begin
        cnt_d = cnt_q - HOLD_W'(1);
      end
    end

    if (state_q == S_CHECK) begin
      if (k1_d || (to_q == TO_LAST)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        pass_d  = k2_d & k1_d & ~spur_q & ~oerr_d;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end

    a_d = (state_d == S_P1) || (state_d == S_P3);
  end

  assign A         = a_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

endmodule
